// File: rtl/msrv32_wb_pipe_unit_if.sv
// Writeback stage bus for msrv32_wb_pipe_unit.
// The master side (execute/load unit) drives the stage inputs and observes
// the operand mux, stall and registered writeback results; the slave side
// is the writeback stage itself.
interface msrv32_wb_pipe_unit_if #(
    parameter int XLEN = 32
);
    // Stage control
    logic            valid_in;
    logic            flush_in;
    logic [2:0]      wb_mux_sel_in;
    logic            wr_en_in;
    logic [4:0]      rd_addr_in;

    // Writeback sources
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] lu_output_in;
    logic [XLEN-1:0] imm_in;
    logic [XLEN-1:0] iadder_out_in;
    logic [XLEN-1:0] csr_data_in;
    logic [XLEN-1:0] pc_plus_4_in;
    logic [XLEN-1:0] rs2_in;
    logic            lu_valid_in;

    // ALU operand select and forwarding lookup addresses
    logic            alu_src_in;
    logic [4:0]      rs1_addr_in;
    logic [4:0]      rs2_addr_in;

    // Stage results
    logic [XLEN-1:0] alu_2nd_src_mux_out;
    logic            stall_out;
    logic [XLEN-1:0] wb_data_out;
    logic [4:0]      rd_addr_out;
    logic            wr_en_out;
    logic            lu_err_out;
    logic            fwd_rs1_hit_out;
    logic            fwd_rs2_hit_out;

    modport master (
        output valid_in, flush_in, wb_mux_sel_in, wr_en_in, rd_addr_in,
               alu_result_in, lu_output_in, imm_in, iadder_out_in,
               csr_data_in, pc_plus_4_in, rs2_in, lu_valid_in,
               alu_src_in, rs1_addr_in, rs2_addr_in,
        input  alu_2nd_src_mux_out, stall_out, wb_data_out, rd_addr_out,
               wr_en_out, lu_err_out, fwd_rs1_hit_out, fwd_rs2_hit_out
    );

    modport slave (
        input  valid_in, flush_in, wb_mux_sel_in, wr_en_in, rd_addr_in,
               alu_result_in, lu_output_in, imm_in, iadder_out_in,
               csr_data_in, pc_plus_4_in, rs2_in, lu_valid_in,
               alu_src_in, rs1_addr_in, rs2_addr_in,
        output alu_2nd_src_mux_out, stall_out, wb_data_out, rd_addr_out,
               wr_en_out, lu_err_out, fwd_rs1_hit_out, fwd_rs2_hit_out
    );
endinterface

// File: rtl/msrv32_wb_pipe_unit.sv
// msrv32 registered writeback stage.
// Selects the writeback source, holds the pipeline while a load result is
// outstanding (aborting after LU_TIMEOUT waiting cycles), and launches a
// one-cycle register-file write strobe. Also hosts the ALU second-operand mux.
// Optional feature macro: MSRV32_WB_FWD_EN enables the writeback-to-operand
// forwarding comparators; when undefined the hit outputs are tied low.
module msrv32_wb_pipe_unit #(
    parameter int XLEN       = 32,
    parameter int LU_TIMEOUT = 16   // 2..255
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    msrv32_wb_pipe_unit_if.slave  wb_if
);

    // Stage states (legacy-compatible encoding)
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_WAIT_LU = 1'b1;

    // Writeback source selector codes; 110/111 fall back to the ALU
    localparam logic [2:0] SEL_ALU    = 3'b000;
    localparam logic [2:0] SEL_LU     = 3'b001;
    localparam logic [2:0] SEL_IMM    = 3'b010;
    localparam logic [2:0] SEL_IADDER = 3'b011;
    localparam logic [2:0] SEL_CSR    = 3'b100;
    localparam logic [2:0] SEL_PC4    = 3'b101;

    // Counter value seen in the last permitted waiting cycle
    localparam logic [7:0] LU_LAST = 8'(LU_TIMEOUT - 1);

    logic            clk;
    logic            rst;
    assign clk = ms_riscv32_mp_clk_in;
    assign rst = ms_riscv32_mp_rst_in;

    // Registered state
    logic [0:0]      state_q,   state_d;
    logic [7:0]      cnt_q,     cnt_d;
    logic [4:0]      pend_rd_q, pend_rd_d;
    logic            pend_we_q, pend_we_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            wr_en_q,   wr_en_d;
    logic            lu_err_q,  lu_err_d;

    // Combinational helpers
    logic [XLEN-1:0] sel_data;
    logic            sel_is_lu;
    logic            rd_nonzero;
    logic            pend_rd_nonzero;
    logic            stall;

    assign sel_is_lu       = (wb_if.wb_mux_sel_in == SEL_LU);
    assign rd_nonzero      = (wb_if.rd_addr_in != 5'd0);
    assign pend_rd_nonzero = (pend_rd_q != 5'd0);

    // ALU second operand: rs2 for register-register ops, immediate otherwise
    assign wb_if.alu_2nd_src_mux_out = wb_if.alu_src_in ? wb_if.rs2_in : wb_if.imm_in;

    // Writeback source selection for the accepting instruction
    always_comb begin
        // NOTE: a default assignment first means every path drives sel_data,
        // so no latch is inferred when a case item is added or missed.
        sel_data = wb_if.alu_result_in;
        case (wb_if.wb_mux_sel_in)
            SEL_ALU:    sel_data = wb_if.alu_result_in;
            SEL_LU:     sel_data = wb_if.lu_output_in;
            SEL_IMM:    sel_data = wb_if.imm_in;
            SEL_IADDER: sel_data = wb_if.iadder_out_in;
            SEL_CSR:    sel_data = wb_if.csr_data_in;
            SEL_PC4:    sel_data = wb_if.pc_plus_4_in;
            default:    sel_data = wb_if.alu_result_in;
        endcase
    end

    // Stage control: accept, load wait, timeout and flush handling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        pend_we_d = pend_we_q;
        wb_data_d = wb_data_q;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        lu_err_d  = 1'b0;
        stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wb_if.valid_in && !wb_if.flush_in) begin
                    if (!sel_is_lu || wb_if.lu_valid_in) begin
                        // Result available now: write next cycle
                        wb_data_d = sel_data;
                        rd_addr_d = wb_if.rd_addr_in;
                        wr_en_d   = wb_if.wr_en_in && rd_nonzero;
                    end else begin
                        // Load outstanding: remember the destination and wait
                        pend_rd_d = wb_if.rd_addr_in;
                        pend_we_d = wb_if.wr_en_in;
                        cnt_d     = 8'd0;
                        state_d   = ST_WAIT_LU;
                        stall     = 1'b1;
                    end
                end
            end

            ST_WAIT_LU: begin
                if (wb_if.flush_in) begin
                    // Killed: drop the pending write silently
                    state_d = ST_IDLE;
                end else if (wb_if.lu_valid_in) begin
                    // Data arrived, even on the timeout count
                    wb_data_d = wb_if.lu_output_in;
                    rd_addr_d = pend_rd_q;
                    wr_en_d   = pend_we_q && pend_rd_nonzero;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LU_LAST) begin
                    // Give up: report the error, suppress the write
                    lu_err_d  = 1'b1;
                    state_d   = ST_IDLE;
                    stall     = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    stall     = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so evaluation order inside the block is irrelevant.
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            pend_rd_q <= 5'd0;
            pend_we_q <= 1'b0;
            wb_data_q <= '0;
            rd_addr_q <= 5'd0;
            wr_en_q   <= 1'b0;
            lu_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            pend_we_q <= pend_we_d;
            wb_data_q <= wb_data_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            lu_err_q  <= lu_err_d;
        end
    end

    // A flush releases upstream immediately
    assign wb_if.stall_out   = stall && !wb_if.flush_in;
    assign wb_if.wb_data_out = wb_data_q;
    assign wb_if.rd_addr_out = rd_addr_q;
    assign wb_if.wr_en_out   = wr_en_q;
    assign wb_if.lu_err_out  = lu_err_q;

`ifdef MSRV32_WB_FWD_EN
    // Forwarding: the register being written this cycle matches a decode source
    assign wb_if.fwd_rs1_hit_out = wr_en_q && (rd_addr_q == wb_if.rs1_addr_in);
    assign wb_if.fwd_rs2_hit_out = wr_en_q && (rd_addr_q == wb_if.rs2_addr_in);
`else
    // Forwarding disabled: hits tied low, lookup addresses only sunk
    logic unused_fwd_addr;
    assign unused_fwd_addr       = ^{wb_if.rs1_addr_in, wb_if.rs2_addr_in};
    assign wb_if.fwd_rs1_hit_out = 1'b0;
    assign wb_if.fwd_rs2_hit_out = 1'b0;
`endif

endmodule
